// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and derived constants for the instruction cache
package icache_pkg;

    localparam int CFG_INDEX_BITS  = 6;
    localparam int CFG_OFFSET_BITS = 2;
    localparam int CFG_ADDR_W      = 32;

    localparam int TAG_W      = CFG_ADDR_W - 2 - CFG_OFFSET_BITS - CFG_INDEX_BITS;
    localparam int LINE_WORDS = 2 ** CFG_OFFSET_BITS;

    localparam logic [31:0] BOOT_VECTOR = 32'h8000_0000;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

endpackage

// File: rtl/icache_fetch_responder_if.sv
// rtl/icache_fetch_responder_if.sv - fetch-side and refill-side signals of the instruction cache
interface icache_fetch_responder_if #(
    parameter int ADDR_W = 32
);
    logic              ce;
    logic [ADDR_W-1:0] inst_address;
    logic              flush;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              stall_pc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  ce, inst_address, flush, mem_ack, mem_rdata,
        output inst, inst_valid, stall_pc, mem_req, mem_addr
    );

    modport master (
        output ce, inst_address, flush, mem_ack, mem_rdata,
        input  inst, inst_valid, stall_pc, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_tag_data_array.sv
// rtl/icache_tag_data_array.sv - valid/tag/data storage, async read, sync write
module icache_tag_data_array #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_BITS    = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_word,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [31:0]            rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [OFFSET_BITS-1:0] wr_word,
    input  logic [31:0]            wr_data,
    input  logic                   tag_wr_en,
    input  logic [TAG_BITS-1:0]    wr_tag,
    input  logic                   set_valid,
    input  logic                   inv_en,
    input  logic [INDEX_BITS-1:0]  inv_index,
    input  logic                   flush_all
);
    localparam int LINES = 2 ** INDEX_BITS;
    localparam int WORDS = 2 ** OFFSET_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [31:0]         data [LINES*WORDS];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[{rd_index, rd_word}];

    // flush wins over everything so a line finishing in the flush cycle stays invalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else begin
            if (inv_en)    valid[inv_index] <= 1'b0;
            if (set_valid) valid[wr_index]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)     data[{wr_index, wr_word}] <= wr_data;
        if (tag_wr_en) tags[wr_index]            <= wr_tag;
    end

endmodule

// File: rtl/icache_fetch_responder.sv
// rtl/icache_fetch_responder.sv - direct-mapped read-only instruction cache with line-burst refill
module icache_fetch_responder
    import icache_pkg::*;
#(
    parameter int INDEX_BITS  = CFG_INDEX_BITS,
    parameter int OFFSET_BITS = CFG_OFFSET_BITS,
    parameter int ADDR_W      = CFG_ADDR_W
) (
    input logic                      clk,
    input logic                      rst,
    icache_fetch_responder_if.slave  bus
);
    localparam int TAG_BITS = ADDR_W - 2 - OFFSET_BITS - INDEX_BITS;
    localparam int TAG_LO   = 2 + OFFSET_BITS + INDEX_BITS;
    localparam int IDX_LO   = 2 + OFFSET_BITS;

    logic [TAG_BITS-1:0]    addr_tag;
    logic [INDEX_BITS-1:0]  addr_index;
    logic [OFFSET_BITS-1:0] addr_word;
    logic                   unused_byte_bits;

    assign addr_tag         = bus.inst_address[ADDR_W-1:TAG_LO];
    assign addr_index       = bus.inst_address[TAG_LO-1:IDX_LO];
    assign addr_word        = bus.inst_address[IDX_LO-1:2];
    assign unused_byte_bits = ^bus.inst_address[1:0];

    state_t                 state;
    logic [OFFSET_BITS-1:0] fill_cnt;
    logic                   drop;
    logic [INDEX_BITS-1:0]  fill_index;
    logic [TAG_BITS-1:0]    fill_tag;
    logic                   req;
    logic [ADDR_W-1:0]      base;

    logic                   rd_valid;
    logic [TAG_BITS-1:0]    rd_tag;
    logic [31:0]            rd_data;
    logic                   hit, lookup, miss, take_ack, final_ack;

    // rst gates the lookup so stall_pc reads 0 while reset is held
    assign lookup    = (state == IDLE) && bus.ce && !rst;
    assign hit       = rd_valid && (rd_tag == addr_tag);
    assign miss      = lookup && !hit;
    assign take_ack  = (state == FILL) && bus.mem_ack;
    assign final_ack = take_ack && (&fill_cnt);

    icache_tag_data_array #(
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (addr_index),
        .rd_word  (addr_word),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (take_ack),
        .wr_index (fill_index),
        .wr_word  (fill_cnt),
        .wr_data  (bus.mem_rdata),
        .tag_wr_en(final_ack),
        .wr_tag   (fill_tag),
        .set_valid(final_ack && !drop && !bus.flush),
        .inv_en   (miss),
        .inv_index(addr_index),
        .flush_all(bus.flush)
    );

    always_comb begin
        bus.inst       = '0;
        bus.inst_valid = 1'b0;
        bus.stall_pc   = 1'b0;
        if (state == FILL) begin
            bus.stall_pc = 1'b1;
        end else if (lookup) begin
            if (hit) begin
                bus.inst       = rd_data;
                bus.inst_valid = 1'b1;
            end else begin
                bus.stall_pc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            drop       <= 1'b0;
            fill_index <= '0;
            fill_tag   <= '0;
            req        <= 1'b0;
            base       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state      <= FILL;
                        req        <= 1'b1;
                        base       <= {bus.inst_address[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}};
                        fill_cnt   <= '0;
                        drop       <= 1'b0;
                        fill_index <= addr_index;
                        fill_tag   <= addr_tag;
                    end
                end
                FILL: begin
                    if (bus.flush) drop <= 1'b1;
                    if (bus.mem_ack) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (&fill_cnt) begin
                            state <= IDLE;
                            req   <= 1'b0;
                            drop  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req  = req;
    assign bus.mem_addr = base;

endmodule
